// File: rtl/genpad_pkg.sv
// Shared constants for the genesis pad reader: FSM encoding, joystick bit
// positions and raw pin positions on the 7-pin pad port.
package genpad_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  // Bit positions in the active-high joystick word
  localparam int J_R     = 0;
  localparam int J_L     = 1;
  localparam int J_D     = 2;
  localparam int J_U     = 3;
  localparam int J_A     = 4;
  localparam int J_B     = 5;
  localparam int J_C     = 6;
  localparam int J_START = 7;
  localparam int J_MODE  = 8;
  localparam int J_X     = 9;
  localparam int J_Y     = 10;
  localparam int J_Z     = 11;

  // Pin positions on user_in / user_out (pins are active low)
  localparam int P_DOWN_Y     = 0;
  localparam int P_UP_Z       = 1;
  localparam int P_TL         = 2;
  localparam int P_RIGHT_MODE = 3;
  localparam int P_TH         = 4;
  localparam int P_LEFT_X     = 5;
  localparam int P_TR         = 6;

endpackage

// File: rtl/genpad_sync.sv
// Two-flop synchronizer for the asynchronous pad pins; resets to 1 so the
// pins read as released (nothing pressed) straight out of reset.
module genpad_sync #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/genpad_reader.sv
// Scans a 3/6-button genesis pad by toggling TH through 8 steps per frame,
// collecting buttons into shadow registers and publishing them atomically.
module genpad_reader
  import genpad_pkg::*;
#(
  parameter int STEP_CYC = 500,
  parameter int IDLE_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  user_in,
  output logic [6:0]  user_out,
  output logic [11:0] joystick,
  output logic        present,
  output logic        six_btn,
  output logic        frame_done,
  output state_t      dbg_state
);

  localparam int MAX_CYC = (IDLE_CYC > STEP_CYC) ? IDLE_CYC : STEP_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);

  logic [6:0]    w_pins;
  logic          w_unused_th;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_idle_done;
  logic          w_step_done;
  logic          w_frame_end;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_k;
  logic          r_th;
  logic [11:0]   r_sh_joy;
  logic          r_sh_present;
  logic          r_sh_six;
  logic [11:0]   r_joy;
  logic          r_present;
  logic          r_six;
  logic          r_frame_done;

  genpad_sync #(.W(7)) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (user_in),
    .o_q   (w_pins)
  );

  // TH is our own output looped back; its synchronized copy is not needed
  assign w_unused_th = w_pins[P_TH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idle_done  = (r_state == ST_IDLE) && (r_cnt == IDLE_LAST);
    w_step_done  = (r_state == ST_STEP) && (r_cnt == STEP_LAST);
    w_frame_end  = w_step_done && (r_k == 3'd7);
    if (!enable) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_idle_done) w_state_next = ST_STEP;
        ST_STEP: if (w_frame_end) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_k          <= 3'd0;
      r_th         <= 1'b1;
      r_sh_joy     <= 12'h000;
      r_sh_present <= 1'b0;
      r_sh_six     <= 1'b0;
      r_joy        <= 12'h000;
      r_present    <= 1'b0;
      r_six        <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!enable) begin
      r_cnt        <= '0;
      r_k          <= 3'd0;
      r_th         <= 1'b1;
      r_sh_joy     <= 12'h000;
      r_sh_present <= 1'b0;
      r_sh_six     <= 1'b0;
      r_joy        <= 12'h000;
      r_present    <= 1'b0;
      r_six        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_idle_done || w_step_done) r_cnt <= '0;
      else                            r_cnt <= r_cnt + CW'(1);

      if (w_step_done) begin
        // Sample on the last clock of the step, before TH moves
        case (r_k)
          3'd0: begin
            r_sh_joy[J_U] <= ~w_pins[P_UP_Z];
            r_sh_joy[J_D] <= ~w_pins[P_DOWN_Y];
            r_sh_joy[J_L] <= ~w_pins[P_LEFT_X];
            r_sh_joy[J_R] <= ~w_pins[P_RIGHT_MODE];
            r_sh_joy[J_B] <= ~w_pins[P_TL];
            r_sh_joy[J_C] <= ~w_pins[P_TR];
          end
          3'd1: begin
            r_sh_joy[J_A]     <= ~w_pins[P_TL];
            r_sh_joy[J_START] <= ~w_pins[P_TR];
            r_sh_present      <= ~w_pins[P_LEFT_X] & ~w_pins[P_RIGHT_MODE];
          end
          3'd5: begin
            r_sh_six <= ~w_pins[P_UP_Z] & ~w_pins[P_DOWN_Y] &
                        ~w_pins[P_LEFT_X] & ~w_pins[P_RIGHT_MODE];
          end
          3'd6: begin
            r_sh_joy[J_Z]    <= r_sh_six & ~w_pins[P_UP_Z];
            r_sh_joy[J_Y]    <= r_sh_six & ~w_pins[P_DOWN_Y];
            r_sh_joy[J_X]    <= r_sh_six & ~w_pins[P_LEFT_X];
            r_sh_joy[J_MODE] <= r_sh_six & ~w_pins[P_RIGHT_MODE];
          end
          default: ;
        endcase

        if (w_frame_end) begin
          r_k          <= 3'd0;
          r_th         <= 1'b1;
          r_joy        <= r_sh_present ? r_sh_joy : 12'h000;
          r_present    <= r_sh_present;
          r_six        <= r_sh_six;
          r_frame_done <= 1'b1;
        end else begin
          // Next step is k+1: TH high when it is even, i.e. when k is odd
          r_k  <= r_k + 3'd1;
          r_th <= r_k[0];
        end
      end
    end
  end

  assign user_out   = {2'b11, r_th, 4'b1111};
  assign joystick   = r_joy;
  assign present    = r_present;
  assign six_btn    = r_six;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: doc/genpad_reader.md
GENPAD_READER -- requirements
Module: genpad_reader

Interface
REQ-001 SHALL have parameter STEP_CYC, default 500, giving the clocks per TH phase (10 us at 50 MHz).
REQ-002 SHALL have parameter IDLE_CYC, default 100000, giving the clocks between scan frames (2 ms at 50 MHz; this lets the pad's internal counter reset).
REQ-003 SHALL have port clk, input, 1 bit: the single clock for the block.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: when low, the pad port is inactive.
REQ-006 SHALL have port user_in, input, 7 bits: raw open-drain pins {6:TR/C/Start, 5:Left/X, 4:TH, 3:Right/Mode, 2:TL/B/A, 1:Up/Z, 0:Down/Y}, active low.
REQ-007 SHALL have port user_out, output, 7 bits: 0 drives the pin low, 1 releases it.
REQ-008 SHALL have port joystick, output, 12 bits: active-high {11:Z,10:Y,9:X,8:Mode,7:Start,6:C,5:B,4:A,3:Up,2:Down,1:Left,0:Right}.
REQ-009 SHALL have port present, output, 1 bit: a pad was detected in the last frame.
REQ-010 SHALL have port six_btn, output, 1 bit: the last frame detected a 6-button pad.
REQ-011 SHALL have port frame_done, output, 1 bit: one-clock pulse when the outputs update.

Function
REQ-012 SHALL pass user_in through a 2-flop synchronizer before any use.
REQ-013 SHALL hold user_out[6:5] and user_out[3:0] at 1 (released) at all times.
REQ-014 SHALL drive only user_out[4] (TH).
REQ-015 SHALL use states IDLE and STEP.
- IDLE: TH=1; counts IDLE_CYC clocks, then goes to STEP with step index k=0.
- STEP: holds k for STEP_CYC clocks; TH = 1 for even k and 0 for odd k, k = 0..7.
REQ-016 SHALL sample the synchronized inputs on the last clock of each step, before TH changes.
REQ-017 SHALL decode each step sample as follows:
- k=0 (TH=1): Up, Down, Left, Right, B, C.
- k=1 (TH=0): A, Start; present_next = (Left low AND Right low).
- k=5 (TH=0): six_next = (Up, Down, Left, Right all low).
- k=6 (TH=1): Z, Y, X, Mode, latched only if six_next=1, otherwise forced to 0.
- Other steps: ignored.
REQ-018 SHALL, after k=7, copy the shadow registers to joystick, present and six_btn in the same clock, pulse frame_done for 1 clock, and return to IDLE.
REQ-019 SHALL force joystick to 12'h000 in that update if present_next=0.
REQ-020 SHALL keep the outputs unchanged during a frame; they update only atomically at frame end.
REQ-021 SHALL invert pin levels: pin low reads as bit 1.
REQ-022 SHALL give a frame length of IDLE_CYC + 8*STEP_CYC clocks, with the first step starting IDLE_CYC clocks after reset release.
REQ-023 SHALL, when enable=0 at any clock (including mid-frame), within 1 clock: go to IDLE, clear the counters and shadow registers, set TH=1, and clear joystick, present and six_btn to 0; no frame_done is issued.
REQ-024 SHALL restart the full IDLE wait when enable returns high.
REQ-025 SHALL size the counters at clog2(max(IDLE_CYC, STEP_CYC)) bits; counter wrap is never reached.

Reset
REQ-026 SHALL, while reset is asserted, hold: state=IDLE, k=0, counters=0, user_out=7'h7F, joystick=0, present=0, six_btn=0, frame_done=0, synchronizer flops=1.
REQ-027 SHALL treat reset asserted mid-frame the same as REQ-026; no partial frame is published.

Structure
REQ-028 SHALL put the state encoding, the joystick bit-index constants (R=0 .. Z=11) and the user_in pin-index constants in package genpad_pkg.
REQ-029 SHALL use one sub-module, genpad_sync: a 7-bit 2-flop synchronizer with reset value 1.

Verification
REQ-030 SHALL cover, with STEP_CYC=4 and IDLE_CYC=20:
- No pad, all pins pulled high: present=0, joystick=000, frame_done every 52 clocks.
- 3-button pad model, A+Up pressed: joystick=0x018, present=1, six_btn=0.
- 6-button pad model, Z+Mode+Start pressed: joystick=0x980, six_btn=1.
- enable dropped at step 3 and raised 10 clocks later: outputs cleared within 1 clock, TH=1, next frame_done 52 clocks after enable rises.
- reset asserted at step 6: user_out=7F immediately, outputs 0, no frame_done.
- Check that TH toggles H,L,H,L,H,L,H,L with each phase exactly 4 clocks wide and all other user_out bits always 1.
